dff_pipe_sync: RTL and testbench

//  Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit D flip-flops

---
 rtl/dff_pipe_sync.sv | 89 ++++++++
 tb/tb_dff_pipe_sync.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe_sync.sv
// rtl/dff_pipe_sync.sv - elastic DEPTH x WIDTH register pipeline with valid/ready, bubble collapse, flush and count
module dff_pipe_sync #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_src_d [DEPTH];
    logic [DEPTH-1:0] w_v_nxt;
    logic [DEPTH-1:0] w_ld;
    logic [CW-1:0]    w_cnt_nxt;

    // A stage is ready if it or any stage downstream of it is empty, or the sink accepts.
    always_comb begin : ready_chain
        logic l_acc;
        l_acc = out_ready;
        w_rdy = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            l_acc    = l_acc | ~r_v[k];
            w_rdy[k] = l_acc;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_src
            if (g == 0) begin : g_first
                assign w_src_v[g] = in_valid;
                assign w_src_d[g] = in_data;
            end else begin : g_rest
                assign w_src_v[g] = r_v[g-1];
                assign w_src_d[g] = r_d[g-1];
            end
        end
    endgenerate

    // Data loads only for a valid source, so idle input data never enters the pipe.
    always_comb begin
        w_ld      = w_rdy & w_src_v & {DEPTH{~flush}};
        w_v_nxt   = flush ? '0 : ((w_rdy & w_src_v) | (~w_rdy & r_v));
        w_cnt_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_cnt_nxt = w_cnt_nxt + CW'(w_v_nxt[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v     <= '0;
            r_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= RESET_VAL;
            end
        end else begin
            r_v     <= w_v_nxt;
            r_count <= w_cnt_nxt;
            for (int k = 0; k < DEPTH; k++) begin
                if (w_ld[k]) begin
                    r_d[k] <= w_src_d[k];
                end
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign count     = r_count;

endmodule

// File: tb/tb_dff_pipe_sync.sv
// tb/tb_dff_pipe_sync.sv - scoreboard bench for dff_pipe_sync against an item-queue reference model
module tb_dff_pipe_sync;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [1:0] count;

    dff_pipe_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: pipe contents as an ordered list of items with their accept edge.
    // The oldest item always has empty stages ahead of it, so it reaches the last
    // stage exactly DEPTH-1 edges after acceptance and sits there until consumed.
    typedef struct {
        logic [7:0] d;
        int         t;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    bit    m_v, m_r, m_acc, m_pop;

    function automatic bit model_out_valid();
        if (q.size() == 0) return 1'b0;
        return (q[0].t + DEPTH - 1 <= cyc);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            m_v   = model_out_valid();
            m_r   = (q.size() < DEPTH) || out_ready;
            m_acc = in_valid && m_r;
            m_pop = m_v && out_ready;
            if (m_pop) begin
                check("pop_data", {24'h0, out_data}, {24'h0, q[0].d});
                void'(q.pop_front());
            end
            if (flush) q.delete();
            else if (m_acc) q.push_back('{d: in_data, t: cyc + 1});
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("count", 32'(count), 32'(q.size()));
            check("out_valid", 32'(out_valid), 32'(model_out_valid()));
            check("in_ready", 32'(in_ready), 32'((q.size() < DEPTH) || out_ready));
            if (model_out_valid()) check("out_data", {24'h0, out_data}, {24'h0, q[0].d});
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic iv, input logic [7:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    initial begin
        // 1: reset with random inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            flush = 1'($urandom);
            set_in(1'($urandom), 8'($urandom), 1'($urandom));
            cycle();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", {24'h0, out_data}, {24'h0, RV});
            check("rst_count", 32'(count), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd1);
        end
        rst = 1'b0;
        flush = 1'b0;
        set_in(1'b0, 8'h00, 1'b1);
        cycle();

        // 2: streaming 01..10, first item visible after its 3rd edge
        for (int i = 1; i <= 16; i++) begin
            set_in(1'b1, 8'(i), 1'b1);
            cycle();
            if (i == 1) check("lat_first_early", 32'(out_valid), 32'd0);
            if (i == 3) check("lat_first_out", {31'h0, out_valid, out_data} , {31'h0, 1'b1, 8'h01});
            if (i == 6) check("stream_count", 32'(count), 32'd3);
        end
        set_in(1'b0, 8'h00, 1'b1);
        repeat (4) cycle();

        // 3: backpressure, 44 held while full
        set_in(1'b1, 8'h11, 1'b0); cycle();
        set_in(1'b1, 8'h22, 1'b0); cycle();
        set_in(1'b1, 8'h33, 1'b0); cycle();
        set_in(1'b1, 8'h44, 1'b0);
        #1;
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_count", 32'(count), 32'd3);
        cycle();
        check("bp_hold_count", 32'(count), 32'd3);
        check("bp_hold_out", {24'h0, out_data}, {24'h0, 8'h11});
        set_in(1'b1, 8'h44, 1'b1); cycle();
        set_in(1'b0, 8'h00, 1'b1);
        repeat (5) cycle();

        // 4: full push/pop
        set_in(1'b1, 8'h11, 1'b0); cycle();
        set_in(1'b1, 8'h22, 1'b0); cycle();
        set_in(1'b1, 8'h33, 1'b0); cycle();
        set_in(1'b1, 8'h55, 1'b1);
        #1;
        check("pp_in_ready_pre", 32'(in_ready), 32'd1);
        cycle();
        check("pp_count", 32'(count), 32'd3);
        check("pp_in_ready", 32'(in_ready), 32'd1);
        check("pp_out", {24'h0, out_data}, {24'h0, 8'h22});

        // 5: flush of a full pipe with a simultaneous input
        set_in(1'b1, 8'h66, 1'b0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("fl_count", 32'(count), 32'd0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        set_in(1'b0, 8'h00, 1'b1);
        repeat (5) cycle();
        check("fl_no_66", 32'(out_valid), 32'd0);

        // 6: reset mid-operation, then latency of first item after reset
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, 8'(8'h80 + i), 1'(i < 2));
            cycle();
        end
        rst = 1'b1;
        cycle();
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_data", {24'h0, out_data}, {24'h0, RV});
        check("mr_count", 32'(count), 32'd0);
        rst = 1'b0;
        set_in(1'b1, 8'h77, 1'b1); cycle();
        set_in(1'b0, 8'h00, 1'b1); cycle();
        check("mr_lat_early", 32'(out_valid), 32'd0);
        cycle();
        check("mr_lat_out", {31'h0, out_valid, out_data}, {31'h0, 1'b1, 8'h77});
        repeat (3) cycle();

        // Randomised traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 23) == 0);
            set_in(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
            cycle();
        end
        rst = 1'b0;
        flush = 1'b0;
        set_in(1'b0, 8'h00, 1'b1);
        repeat (6) cycle();
        check("drain_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
